// File: rtl/spw_rx_sync_multi.sv
// SpaceWire RX-to-system synchroniser: N_CH status lines plus a strobed word with valid/ready and overrun.
// Optional stability filter on the lines and strobe: define SPW_SYNC_GLITCH_FILTER_EN.
module spw_rx_sync_multi #(
  parameter int              N_CH        = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              DATA_W      = 9,
  parameter logic [N_CH-1:0] EDGE_MASK   = {N_CH{1'b1}},
  parameter int              FILTER_LEN  = 3
) (
  input  logic              CLOCK,
  input  logic              RESETn,
  input  logic [N_CH-1:0]   SIG_IN,
  output logic [N_CH-1:0]   SIG_OUT,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DATA_STB,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              OVERRUN,
  input  logic              OVERRUN_CLR
);

  localparam int SW = N_CH + 1 + DATA_W;

  if (SYNC_STAGES < 2) begin : gBadStages
    $error("SYNC_STAGES must be at least 2");
  end

  if (FILTER_LEN < 1) begin : gBadFilter
    $error("FILTER_LEN must be at least 1");
  end

  logic [SW-1:0] syncD [SYNC_STAGES];
  logic [SW-1:0] syncQ [SYNC_STAGES];

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : gStage
    if (g == 0) begin : gFirst
      assign syncD[g] = {DATA_IN, DATA_STB, SIG_IN};
    end else begin : gNext
      assign syncD[g] = syncQ[g-1];
    end

    always_ff @(posedge CLOCK) begin
      if (!RESETn) begin
        syncQ[g] <= '0;
      end else begin
        syncQ[g] <= syncD[g];
      end
    end
  end

  logic [SW-1:0]     sLast;
  logic [N_CH-1:0]   sSig;
  logic              sStb;
  logic [DATA_W-1:0] sData;

  assign sLast = syncQ[SYNC_STAGES-1];
  assign sSig  = sLast[N_CH-1:0];
  assign sStb  = sLast[N_CH];
  assign sData = sLast[SW-1:N_CH+1];

  // Bit N_CH of these vectors carries the strobe alongside the lines.
  logic [N_CH:0] raw;
  logic [N_CH:0] filt;

  assign raw = {sStb, sSig};

`ifdef SPW_SYNC_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  for (genvar g = 0; g <= N_CH; g++) begin : gFilt
    logic [CW-1:0] cntQ;
    logic          fQ;

    always_ff @(posedge CLOCK) begin
      if (!RESETn) begin
        cntQ <= '0;
        fQ   <= 1'b0;
      end else if (raw[g] != fQ) begin
        if (cntQ == CW'(FILTER_LEN - 1)) begin
          fQ   <= raw[g];
          cntQ <= '0;
        end else begin
          cntQ <= cntQ + CW'(1);
        end
      end else begin
        cntQ <= '0;
      end
    end

    assign filt[g] = fQ;
  end
`else
  assign filt = raw;
`endif

  logic [N_CH:0]     histQ;
  logic [N_CH-1:0]   pulseQ;
  logic              stbPulseQ;
  logic [DATA_W-1:0] wordQ;

  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      histQ     <= '0;
      pulseQ    <= '0;
      stbPulseQ <= 1'b0;
      wordQ     <= '0;
    end else begin
      histQ     <= filt;
      pulseQ    <= filt[N_CH-1:0] & ~histQ[N_CH-1:0] & EDGE_MASK;
      stbPulseQ <= filt[N_CH] & ~histQ[N_CH];
      if (filt[N_CH] && !histQ[N_CH]) begin
        wordQ <= sData;
      end
    end
  end

  assign SIG_OUT = (pulseQ & EDGE_MASK) | (filt[N_CH-1:0] & ~EDGE_MASK);

  logic [DATA_W-1:0] dataQ;
  logic [DATA_W-1:0] dataD;
  logic              validQ;
  logic              validD;
  logic              overrunQ;
  logic              overrunD;
  logic              acceptC;
  logic              dropC;
  logic              consumeC;

  assign acceptC  = stbPulseQ & (~validQ | DATA_READY);
  assign dropC    = stbPulseQ & validQ & ~DATA_READY;
  assign consumeC = ~stbPulseQ & validQ & DATA_READY;

  always_comb begin
    dataD    = dataQ;
    validD   = validQ;
    overrunD = overrunQ & ~OVERRUN_CLR;
    unique case (1'b1)
      acceptC: begin
        dataD  = wordQ;
        validD = 1'b1;
      end
      dropC: begin
        overrunD = 1'b1;
      end
      consumeC: begin
        validD = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      dataQ    <= '0;
      validQ   <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      dataQ    <= dataD;
      validQ   <= validD;
      overrunQ <= overrunD;
    end
  end

  assign DATA_OUT   = dataQ;
  assign DATA_VALID = validQ;
  assign OVERRUN    = overrunQ;

endmodule
